// File: rtl/game_sequencer.sv
// Game flow controller: sequences the enemy spawner through idle/play/break/over
// and tracks player health, score, wave and the hit-flash indicator.
module game_sequencer #(
    parameter int unsigned MAX_HEALTH   = 3,
    parameter int unsigned WAVE_ENEMIES = 8,
    parameter int unsigned BREAK_TICKS  = 100,
    parameter int unsigned FLASH_TICKS  = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       enemy_attack,
    input  logic       kill,
    output logic [3:0] game_state,
    output logic       enemy_start,
    output logic       enemy_hold,
    output logic [2:0] health,
    output logic [7:0] score,
    output logic [3:0] wave,
    output logic       hit_flash
);

    localparam int unsigned HEALTH_W = 3;
    localparam int unsigned SCORE_W  = 8;
    localparam int unsigned WAVE_W   = 4;
    localparam int unsigned KILL_W   = 8;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_PLAY  = 4'b0010,
        S_BREAK = 4'b0100,
        S_OVER  = 4'b1000
    } state_t;

    state_t              r_state;
    logic                r_start_prev;
    logic                r_enemy_start;
    logic                r_hold;
    logic [HEALTH_W-1:0] r_health;
    logic [SCORE_W-1:0]  r_score;
    logic [WAVE_W-1:0]   r_wave;
    logic [KILL_W-1:0]   r_kill_cnt;
    logic [CNT_W-1:0]    r_break_cnt;
    logic [CNT_W-1:0]    r_flash_cnt;
    logic                r_hit_flash;

    logic                w_start_edge;
    logic                w_play_atk;
    logic                w_play_kill;
    logic                w_dead;
    logic                w_wave_done;
    logic [HEALTH_W-1:0] w_health_dec;
    logic [SCORE_W-1:0]  w_score_inc;
    logic [WAVE_W-1:0]   w_wave_inc;
    logic [CNT_W-1:0]    w_flash_nxt;

    // Attack and kill pulses only matter during active play.
    assign w_start_edge = start_btn & ~r_start_prev;
    assign w_play_atk   = (r_state == S_PLAY) & enemy_attack;
    assign w_play_kill  = (r_state == S_PLAY) & kill;
    assign w_dead       = w_play_atk & (r_health == HEALTH_W'(1));
    assign w_wave_done  = w_play_kill & (r_kill_cnt == KILL_W'(WAVE_ENEMIES - 1));

    // Saturating arithmetic for the player stats.
    assign w_health_dec = (r_health == '0) ? '0 : r_health - HEALTH_W'(1);
    assign w_score_inc  = (r_score == '1) ? r_score : r_score + SCORE_W'(1);
    assign w_wave_inc   = (r_wave == '1) ? r_wave : r_wave + WAVE_W'(1);

    // Flash counter: a fresh hit reloads it, otherwise it drains on tick.
    always_comb begin
        w_flash_nxt = r_flash_cnt;
        if (w_play_atk) begin
            w_flash_nxt = CNT_W'(FLASH_TICKS);
        end else if (tick && (r_flash_cnt != '0)) begin
            w_flash_nxt = r_flash_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_start_prev  <= 1'b1;
            r_enemy_start <= 1'b0;
            r_hold        <= 1'b1;
            r_health      <= HEALTH_W'(MAX_HEALTH);
            r_score       <= '0;
            r_wave        <= '0;
            r_kill_cnt    <= '0;
            r_break_cnt   <= '0;
            r_flash_cnt   <= '0;
            r_hit_flash   <= 1'b0;
        end else begin
            r_start_prev  <= start_btn;
            r_enemy_start <= 1'b0;
            r_flash_cnt   <= w_flash_nxt;
            r_hit_flash   <= (w_flash_nxt != '0);

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state       <= S_PLAY;
                        r_wave        <= WAVE_W'(1);
                        r_enemy_start <= 1'b1;
                        r_hold        <= 1'b0;
                    end
                end

                S_PLAY: begin
                    if (w_play_atk) begin
                        r_health <= w_health_dec;
                    end
                    if (w_play_kill) begin
                        r_score    <= w_score_inc;
                        r_kill_cnt <= w_wave_done ? '0 : r_kill_cnt + KILL_W'(1);
                    end
                    // Losing the last health point outranks clearing the wave.
                    if (w_dead) begin
                        r_state <= S_OVER;
                        r_hold  <= 1'b1;
                    end else if (w_wave_done) begin
                        r_state     <= S_BREAK;
                        r_hold      <= 1'b1;
                        r_break_cnt <= CNT_W'(BREAK_TICKS);
                        r_wave      <= w_wave_inc;
                    end
                end

                S_BREAK: begin
                    // A count of 0 or 1 means this tick ends the pause.
                    if (tick) begin
                        if (r_break_cnt <= CNT_W'(1)) begin
                            r_state       <= S_PLAY;
                            r_hold        <= 1'b0;
                            r_enemy_start <= 1'b1;
                            r_break_cnt   <= '0;
                        end else begin
                            r_break_cnt <= r_break_cnt - CNT_W'(1);
                        end
                    end
                end

                S_OVER: begin
                    if (w_start_edge) begin
                        r_state     <= S_IDLE;
                        r_health    <= HEALTH_W'(MAX_HEALTH);
                        r_score     <= '0;
                        r_wave      <= '0;
                        r_kill_cnt  <= '0;
                        r_break_cnt <= '0;
                        r_flash_cnt <= '0;
                        r_hit_flash <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b1;
                end
            endcase
        end
    end

    assign game_state  = r_state;
    assign enemy_start = r_enemy_start;
    assign enemy_hold  = r_hold;
    assign health      = r_health;
    assign score       = r_score;
    assign wave        = r_wave;
    assign hit_flash   = r_hit_flash;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random traffic, every cycle
// checked against a behavioural model of the game rules.
module tb_game_sequencer;

    localparam int MAX_H  = 3;
    localparam int WAVE_N = 8;
    localparam int BRK    = 100;
    localparam int FLASH  = 25;

    localparam int ST_IDLE  = 0;
    localparam int ST_PLAY  = 1;
    localparam int ST_BREAK = 2;
    localparam int ST_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       enemy_attack = 1'b0;
    logic       kill = 1'b0;
    logic [3:0] game_state;
    logic       enemy_start;
    logic       enemy_hold;
    logic [2:0] health;
    logic [7:0] score;
    logic [3:0] wave;
    logic       hit_flash;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the game as the player sees it.
    int m_st, m_prev, m_health, m_score, m_wave, m_kills, m_brk, m_flash, m_start;

    always #5 clk = ~clk;

    game_sequencer #(
        .MAX_HEALTH  (MAX_H),
        .WAVE_ENEMIES(WAVE_N),
        .BREAK_TICKS (BRK),
        .FLASH_TICKS (FLASH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start_btn   (start_btn),
        .enemy_attack(enemy_attack),
        .kill        (kill),
        .game_state  (game_state),
        .enemy_start (enemy_start),
        .enemy_hold  (enemy_hold),
        .health      (health),
        .score       (score),
        .wave        (wave),
        .hit_flash   (hit_flash)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_st     = ST_IDLE;
        m_health = MAX_H;
        m_score  = 0;
        m_wave   = 0;
        m_kills  = 0;
        m_brk    = 0;
        m_flash  = 0;
        m_start  = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input bit b, input bit a, input bit k);
        bit edge_seen;
        bit dead;
        if (r) begin
            model_clear();
            m_prev = 1;
            return;
        end
        edge_seen = b && (m_prev == 0);
        m_prev    = b;
        m_start   = 0;
        if (m_st == ST_PLAY && a) m_flash = FLASH;
        else if (t && m_flash > 0) m_flash = m_flash - 1;
        case (m_st)
            ST_IDLE: if (edge_seen) begin
                m_st = ST_PLAY; m_wave = 1; m_start = 1;
            end
            ST_PLAY: begin
                dead = a && (m_health == 1);
                if (a) m_health = (m_health > 0) ? m_health - 1 : 0;
                if (k) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_kills = m_kills + 1;
                end
                if (dead) m_st = ST_OVER;
                if (m_kills == WAVE_N) begin
                    m_kills = 0;
                    if (!dead) begin
                        m_st   = ST_BREAK;
                        m_brk  = BRK;
                        m_wave = (m_wave < 15) ? m_wave + 1 : 15;
                    end
                end
            end
            ST_BREAK: if (t) begin
                if (m_brk > 0) m_brk = m_brk - 1;
                if (m_brk == 0) begin
                    m_st = ST_PLAY; m_start = 1;
                end
            end
            default: if (edge_seen) model_clear();
        endcase
    endtask

    // One clock: apply inputs, advance model, compare every output after the edge.
    task automatic step(input bit r, input bit t, input bit a, input bit k);
        rst = r; tick = t; enemy_attack = a; kill = k;
        @(posedge clk);
        model_step(r, t, start_btn, a, k);
        #1;
        chk("state",   32'(game_state),  32'(1 << m_st));
        chk("e_start", 32'(enemy_start), 32'(m_start));
        chk("e_hold",  32'(enemy_hold),  32'(m_st != ST_PLAY));
        chk("health",  32'(health),      32'(m_health));
        chk("score",   32'(score),       32'(m_score));
        chk("wave",    32'(wave),        32'(m_wave));
        chk("flash",   32'(hit_flash),   32'(m_flash != 0));
        rst = 1'b0; tick = 1'b0; enemy_attack = 1'b0; kill = 1'b0;
    endtask

    task automatic go_play();
        for (int i = 0; i < 8 && m_st != ST_PLAY; i++) begin
            start_btn = ~start_btn;
            step(0, 0, 0, 0);
        end
        start_btn = 1'b0;
        step(0, 0, 0, 0);
        chk("go_play", 32'(game_state), 32'h2);
    endtask

    task automatic clear_wave();
        for (int i = 0; i < WAVE_N; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
    endtask

    task automatic drain_break();
        for (int i = 0; i < 1000 && m_st == ST_BREAK; i++) step(0, 1, 0, 0);
        chk("drain_break", 32'(game_state), 32'h2);
    endtask

    initial begin
        int starts;
        int lows;
        int n;
        model_clear();
        m_prev = 1;

        // Button held through reset must not start the game.
        start_btn = 1'b1;
        repeat (3) step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        chk("held_idle", 32'(game_state), 32'h1);
        chk("held_hold", 32'(enemy_hold), 32'h1);
        start_btn = 1'b0;
        repeat (2) step(0, 0, 0, 0);
        start_btn = 1'b1;
        step(0, 0, 0, 0);
        chk("first_play", 32'(game_state), 32'h2);
        chk("first_start", 32'(enemy_start), 32'h1);
        chk("first_wave", 32'(wave), 32'h1);
        step(0, 0, 0, 0);
        chk("start_one_cycle", 32'(enemy_start), 32'h0);
        start_btn = 1'b0;

        // Clear a wave, ignore kills in break, then resume on the 100th tick.
        clear_wave();
        chk("break_state", 32'(game_state), 32'h4);
        chk("break_score", 32'(score), 32'd8);
        chk("break_wave", 32'(wave), 32'd2);
        repeat (3) step(0, 0, 0, 1);
        chk("break_kill_ign", 32'(score), 32'd8);
        starts = 0;
        for (int i = 0; i < BRK; i++) begin
            if (i == BRK - 1) chk("break_pre_exit", 32'(game_state), 32'h4);
            step(0, 1, 0, 0);
            starts += int'(enemy_start);
        end
        chk("break_exit", 32'(game_state), 32'h2);
        repeat (3) begin
            step(0, 0, 0, 0);
            starts += int'(enemy_start);
        end
        chk("break_starts", 32'(starts), 32'd1);

        // Second hit re-arms the flash; it must stay high and drop 25 ticks later.
        step(0, 0, 1, 0);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            if (!hit_flash) lows++;
        end
        step(0, 0, 1, 0);
        if (!hit_flash) lows++;
        n = 0;
        while (hit_flash && n < 100) begin
            step(0, 1, 0, 0);
            n++;
        end
        chk("flash_len", 32'(n), 32'd25);
        chk("flash_gap", 32'(lows), 32'd0);

        // Third attack ends the game; stats then freeze.
        repeat (9) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("over_state", 32'(game_state), 32'h8);
        chk("over_health", 32'(health), 32'd0);
        repeat (3) step(0, 0, 0, 1);
        chk("over_frozen", 32'(score), 32'd8);

        // Attack and the wave-ending kill together at health 1: game over wins.
        go_play();
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_health", 32'(health), 32'd3);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < WAVE_N - 1; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("tie_state", 32'(game_state), 32'h8);
        chk("tie_score", 32'(score), 32'd8);
        chk("tie_wave", 32'(wave), 32'd1);

        // Reset in the middle of a break.
        go_play();
        clear_wave();
        drain_break();
        clear_wave();
        chk("mid_wave", 32'(wave), 32'd3);
        step(1, 0, 0, 0);
        chk("rst_state", 32'(game_state), 32'h1);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_wave", 32'(wave), 32'd0);
        chk("rst_health", 32'(health), 32'd3);
        chk("rst_hold", 32'(enemy_hold), 32'h1);

        // Long game: score saturates at 255 and wave at 15.
        go_play();
        for (int i = 0; i < 20000 && m_score < 255; i++) begin
            if (m_st == ST_PLAY) step(0, 0, 0, 1);
            else step(0, 1, 0, 0);
        end
        drain_break();
        step(0, 0, 0, 1);
        chk("sat_score", 32'(score), 32'd255);
        chk("sat_wave", 32'(wave), 32'd15);

        // Random traffic.
        step(1, 0, 0, 0);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
            step($urandom_range(0, 2999) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
